// File: rtl/regfile_sb.sv
// ============================================================================
// Module      : regfile_sb
// Description : Register file with a banked supervisor stack pointer,
//               write-through bypass on every read path and a per-register
//               pending-write scoreboard with claim/flush handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_sb #(
  parameter int WIDTH  = 32,
  parameter int COUNTP = 4,
  parameter int SPREG  = (2**COUNTP) - 1,
  parameter int NREAD  = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      supervisor,
  input  logic [NREAD*COUNTP-1:0]   read_addr,
  output logic [NREAD*WIDTH-1:0]    read_data,
  output logic [NREAD-1:0]          read_busy,
  input  logic [COUNTP-1:0]         write_addr,
  input  logic [WIDTH-1:0]          write_data,
  input  logic [1:0]                write_en,
  input  logic [WIDTH-1:0]          sp_data_i,
  input  logic [1:0]                sp_en,
  output logic [WIDTH-1:0]          sp_data_o,
  input  logic                      claim_valid,
  input  logic [COUNTP-1:0]         claim_addr,
  output logic                      claim_ready,
  input  logic                      flush,
  output logic [COUNTP:0]           pending_cnt
);

  localparam int                COUNT     = 2**COUNTP;
  localparam logic [COUNTP-1:0] c_SP_ADDR = COUNTP'(SPREG);

  logic [WIDTH-1:0]  r_regs [COUNT];
  logic [WIDTH-1:0]  r_ssp;
  logic [COUNT-1:0]  r_pending;
  logic [COUNTP:0]   r_pending_cnt;

  logic              w_gen_we;
  logic              w_sp_we;
  logic              w_sp_to_rf;
  logic              w_sp_to_ssp;
  logic [WIDTH-1:0]  w_gen_val;
  logic [WIDTH-1:0]  w_sp_val;
  logic [WIDTH-1:0]  w_ssp_vis;
  logic [COUNT-1:0]  w_pend_vis;
  logic              w_claim_acc;
  logic [COUNT-1:0]  w_pend_next;
  logic [COUNTP:0]   w_cnt_next;

  function automatic logic [WIDTH-1:0] f_ext(input logic [WIDTH-1:0] d,
                                             input logic [1:0]       en);
    logic [WIDTH-1:0] v;
    v = '0;
    case (en)
      2'b01:   v[7:0]  = d[7:0];
      2'b10:   v[15:0] = d[15:0];
      default: v       = d;
    endcase
    return v;
  endfunction

  assign w_gen_we    = (write_en != 2'b00);
  assign w_sp_we     = (sp_en != 2'b00);
  assign w_sp_to_rf  = w_sp_we & ~supervisor;
  assign w_sp_to_ssp = w_sp_we & supervisor;
  assign w_gen_val   = f_ext(write_data, write_en);
  assign w_sp_val    = f_ext(sp_data_i, sp_en);

  // While reset is asserted the stored state is presented as already zeroed.
  assign w_ssp_vis   = rst_i ? r_ssp : '0;
  assign w_pend_vis  = rst_i ? r_pending : '0;

  function automatic logic [WIDTH-1:0] f_read(input logic [COUNTP-1:0] addr);
    logic [WIDTH-1:0] v;
    if (supervisor && (addr == c_SP_ADDR))
      v = w_sp_we ? w_sp_val : w_ssp_vis;
    else if (w_sp_to_rf && (addr == c_SP_ADDR))
      v = w_sp_val;
    else if (w_gen_we && (addr == write_addr))
      v = w_gen_val;
    else
      v = rst_i ? r_regs[addr] : '0;
    return v;
  endfunction

  generate
    for (genvar k = 0; k < NREAD; k++) begin : g_rd
      logic [COUNTP-1:0] w_addr;
      assign w_addr                      = read_addr[k*COUNTP +: COUNTP];
      assign read_data[k*WIDTH +: WIDTH] = f_read(w_addr);
      assign read_busy[k]                = w_pend_vis[w_addr]
                                         & ~(w_gen_we && (write_addr == w_addr))
                                         & (w_addr != c_SP_ADDR);
    end
  endgenerate

  assign sp_data_o = f_read(c_SP_ADDR);

  // A write landing on the claimed register this cycle frees it for reclaim.
  assign claim_ready = ~flush
                     & (claim_addr != c_SP_ADDR)
                     & (~w_pend_vis[claim_addr] | (w_gen_we && (write_addr == claim_addr)));
  assign w_claim_acc = claim_valid & claim_ready;

  always_comb begin
    w_pend_next = r_pending;
    if (flush) begin
      w_pend_next = '0;
    end else begin
      if (w_gen_we)
        w_pend_next[write_addr] = 1'b0;
      if (w_claim_acc)
        w_pend_next[claim_addr] = 1'b1;
    end
  end

  always_comb begin
    w_cnt_next = '0;
    for (int i = 0; i < COUNT; i++)
      w_cnt_next = w_cnt_next + (COUNTP+1)'(w_pend_next[i]);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < COUNT; i++)
        r_regs[i] <= '0;
      r_ssp         <= '0;
      r_pending     <= '0;
      r_pending_cnt <= '0;
    end else begin
      if (w_gen_we)
        r_regs[write_addr] <= w_gen_val;
      // Later assignment gives the SP port priority on a shared target.
      if (w_sp_to_rf)
        r_regs[c_SP_ADDR] <= w_sp_val;
      if (w_sp_to_ssp)
        r_ssp <= w_sp_val;
      r_pending     <= w_pend_next;
      r_pending_cnt <= w_cnt_next;
    end
  end

  assign pending_cnt = r_pending_cnt;

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// ============================================================================
// Module      : tb_regfile_sb
// Description : Directed self-checking bench for regfile_sb.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_sb;

  logic        clk;
  logic        rst_i;
  logic        supervisor;
  logic [7:0]  read_addr;
  logic [63:0] read_data;
  logic [1:0]  read_busy;
  logic [3:0]  write_addr;
  logic [31:0] write_data;
  logic [1:0]  write_en;
  logic [31:0] sp_data_i;
  logic [1:0]  sp_en;
  logic [31:0] sp_data_o;
  logic        claim_valid;
  logic [3:0]  claim_addr;
  logic        claim_ready;
  logic        flush;
  logic [4:0]  pending_cnt;

  int n_cmp = 0;
  int n_err = 0;

  regfile_sb dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .supervisor  (supervisor),
    .read_addr   (read_addr),
    .read_data   (read_data),
    .read_busy   (read_busy),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .write_en    (write_en),
    .sp_data_i   (sp_data_i),
    .sp_en       (sp_en),
    .sp_data_o   (sp_data_o),
    .claim_valid (claim_valid),
    .claim_addr  (claim_addr),
    .claim_ready (claim_ready),
    .flush       (flush),
    .pending_cnt (pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    write_en    = 2'b00;
    write_addr  = 4'd0;
    write_data  = 32'h0;
    sp_en       = 2'b00;
    sp_data_i   = 32'h0;
    claim_valid = 1'b0;
    claim_addr  = 4'd0;
    flush       = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; supervisor = 1'b0; idle();
    read_addr = {4'd15, 4'd3};
    step(); step(); #1;
    n_cmp++; if (pending_cnt !== 5'd0) begin n_err++; $display("FAIL rst_cnt: got %0d want 0", pending_cnt); end
    n_cmp++; if (read_busy !== 2'b00) begin n_err++; $display("FAIL rst_busy: got %b want 00", read_busy); end
    rst_i = 1'b1;
    step(); #1;
    n_cmp++; if (read_data[31:0] !== 32'h0) begin n_err++; $display("FAIL rst_r3: got %h want 0", read_data[31:0]); end
    n_cmp++; if (sp_data_o !== 32'h0) begin n_err++; $display("FAIL rst_sp: got %h want 0", sp_data_o); end
    n_cmp++; if (claim_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", claim_ready); end
  endtask

  task automatic test_write_ext();
    read_addr = {4'd3, 4'd3};
    write_addr = 4'd3; write_data = 32'hDEADBEEF; write_en = 2'b11; #1;
    n_cmp++; if (read_data[31:0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_byp32: got %h want deadbeef", read_data[31:0]); end
    step();
    write_data = 32'h12345678; write_en = 2'b01; #1;
    n_cmp++; if (read_data[63:32] !== 32'h00000078) begin n_err++; $display("FAIL wr_byp8: got %h want 00000078", read_data[63:32]); end
    step(); idle(); #1;
    n_cmp++; if (read_data[31:0] !== 32'h00000078) begin n_err++; $display("FAIL wr_r3: got %h want 00000078", read_data[31:0]); end
    write_addr = 4'd4; write_data = 32'hCAFEF00D; write_en = 2'b10;
    step(); idle(); read_addr = {4'd3, 4'd4}; #1;
    n_cmp++; if (read_data[31:0] !== 32'h0000F00D) begin n_err++; $display("FAIL wr_r4_16: got %h want 0000f00d", read_data[31:0]); end
  endtask

  task automatic test_sp();
    read_addr = {4'd0, 4'd15};
    supervisor = 1'b1; sp_en = 2'b11; sp_data_i = 32'h1000; #1;
    n_cmp++; if (sp_data_o !== 32'h1000) begin n_err++; $display("FAIL sp_byp: got %h want 00001000", sp_data_o); end
    step(); idle(); #1;
    n_cmp++; if (read_data[31:0] !== 32'h1000) begin n_err++; $display("FAIL sp_ssp: got %h want 00001000", read_data[31:0]); end
    supervisor = 1'b0; #1;
    n_cmp++; if (read_data[31:0] !== 32'h0) begin n_err++; $display("FAIL sp_r15: got %h want 0", read_data[31:0]); end
    n_cmp++; if (sp_data_o !== 32'h0) begin n_err++; $display("FAIL sp_usr: got %h want 0", sp_data_o); end
    sp_en = 2'b10; sp_data_i = 32'hABCD1234;
    write_en = 2'b11; write_addr = 4'd15; write_data = 32'h55; #1;
    n_cmp++; if (read_data[31:0] !== 32'h00001234) begin n_err++; $display("FAIL sp_prio_byp: got %h want 00001234", read_data[31:0]); end
    step(); idle(); #1;
    n_cmp++; if (sp_data_o !== 32'h00001234) begin n_err++; $display("FAIL sp_prio: got %h want 00001234", sp_data_o); end
    supervisor = 1'b1; write_en = 2'b11; write_addr = 4'd15; write_data = 32'h77; #1;
    n_cmp++; if (sp_data_o !== 32'h1000) begin n_err++; $display("FAIL sp_bank: got %h want 00001000", sp_data_o); end
    step(); idle(); supervisor = 1'b0; #1;
    n_cmp++; if (read_data[31:0] !== 32'h77) begin n_err++; $display("FAIL sp_r15w: got %h want 00000077", read_data[31:0]); end
  endtask

  task automatic test_scoreboard();
    read_addr = {4'd15, 4'd5};
    claim_valid = 1'b1; claim_addr = 4'd5; #1;
    n_cmp++; if (claim_ready !== 1'b1) begin n_err++; $display("FAIL sb_ready1: got %b want 1", claim_ready); end
    step(); #1;
    n_cmp++; if (read_busy !== 2'b01) begin n_err++; $display("FAIL sb_busy: got %b want 01", read_busy); end
    n_cmp++; if (pending_cnt !== 5'd1) begin n_err++; $display("FAIL sb_cnt1: got %0d want 1", pending_cnt); end
    n_cmp++; if (claim_ready !== 1'b0) begin n_err++; $display("FAIL sb_ready2: got %b want 0", claim_ready); end
    claim_valid = 1'b0; write_en = 2'b11; write_addr = 4'd5; write_data = 32'h55; #1;
    n_cmp++; if (read_busy !== 2'b00) begin n_err++; $display("FAIL sb_busyclr: got %b want 00", read_busy); end
    step(); idle(); #1;
    n_cmp++; if (pending_cnt !== 5'd0) begin n_err++; $display("FAIL sb_cnt0: got %0d want 0", pending_cnt); end
    claim_addr = 4'd15; #1;
    n_cmp++; if (claim_ready !== 1'b0) begin n_err++; $display("FAIL sb_spreg: got %b want 0", claim_ready); end
  endtask

  task automatic test_claim_write_same();
    read_addr = {4'd0, 4'd5};
    claim_valid = 1'b1; claim_addr = 4'd5;
    step();
    write_en = 2'b11; write_addr = 4'd5; write_data = 32'hA5A5A5A5; #1;
    n_cmp++; if (claim_ready !== 1'b1) begin n_err++; $display("FAIL cw_ready: got %b want 1", claim_ready); end
    step(); idle(); #1;
    n_cmp++; if (read_busy[0] !== 1'b1) begin n_err++; $display("FAIL cw_busy: got %b want 1", read_busy[0]); end
    n_cmp++; if (pending_cnt !== 5'd1) begin n_err++; $display("FAIL cw_cnt: got %0d want 1", pending_cnt); end
    n_cmp++; if (read_data[31:0] !== 32'hA5A5A5A5) begin n_err++; $display("FAIL cw_data: got %h want a5a5a5a5", read_data[31:0]); end
    write_en = 2'b11; write_addr = 4'd5; write_data = 32'h0;
    step(); idle();
  endtask

  task automatic test_flush();
    claim_valid = 1'b1;
    claim_addr = 4'd1; step();
    claim_addr = 4'd2; step();
    claim_addr = 4'd4; step();
    claim_valid = 1'b0; #1;
    n_cmp++; if (pending_cnt !== 5'd3) begin n_err++; $display("FAIL fl_cnt3: got %0d want 3", pending_cnt); end
    flush = 1'b1; claim_valid = 1'b1; claim_addr = 4'd6;
    write_en = 2'b11; write_addr = 4'd7; write_data = 32'h99; #1;
    n_cmp++; if (claim_ready !== 1'b0) begin n_err++; $display("FAIL fl_ready: got %b want 0", claim_ready); end
    step(); idle(); read_addr = {4'd1, 4'd6}; #1;
    n_cmp++; if (pending_cnt !== 5'd0) begin n_err++; $display("FAIL fl_cnt0: got %0d want 0", pending_cnt); end
    n_cmp++; if (read_busy !== 2'b00) begin n_err++; $display("FAIL fl_busy: got %b want 00", read_busy); end
    read_addr = {4'd0, 4'd7}; #1;
    n_cmp++; if (read_data[31:0] !== 32'h99) begin n_err++; $display("FAIL fl_wr: got %h want 00000099", read_data[31:0]); end
  endtask

  task automatic test_reset_mid();
    write_en = 2'b11; write_addr = 4'd1; write_data = 32'h11; step();
    write_addr = 4'd2; write_data = 32'h22; step();
    idle(); claim_valid = 1'b1;
    claim_addr = 4'd1; step();
    claim_addr = 4'd2; step();
    idle(); read_addr = {4'd2, 4'd1}; #1;
    n_cmp++; if (read_busy !== 2'b11) begin n_err++; $display("FAIL rm_busy_pre: got %b want 11", read_busy); end
    rst_i = 1'b0; write_en = 2'b11; write_addr = 4'd9; write_data = 32'h9;
    read_addr = {4'd1, 4'd9}; #1;
    n_cmp++; if (read_data[31:0] !== 32'h9) begin n_err++; $display("FAIL rm_byp: got %h want 00000009", read_data[31:0]); end
    step(); idle(); rst_i = 1'b1; read_addr = {4'd2, 4'd1}; #1;
    n_cmp++; if (read_data !== 64'h0) begin n_err++; $display("FAIL rm_reads: got %h want 0", read_data); end
    n_cmp++; if (read_busy !== 2'b00) begin n_err++; $display("FAIL rm_busy: got %b want 00", read_busy); end
    n_cmp++; if (pending_cnt !== 5'd0) begin n_err++; $display("FAIL rm_cnt: got %0d want 0", pending_cnt); end
    read_addr = {4'd3, 4'd9}; #1;
    n_cmp++; if (read_data !== 64'h0) begin n_err++; $display("FAIL rm_r9r3: got %h want 0", read_data); end
    supervisor = 1'b1; #1;
    n_cmp++; if (sp_data_o !== 32'h0) begin n_err++; $display("FAIL rm_ssp: got %h want 0", sp_data_o); end
    supervisor = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_ext();
    test_sp();
    test_scoreboard();
    test_claim_write_same();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits (minimum 16).
REQ-002 SHALL have parameter COUNTP, default 4, register address width; register count COUNT = 2**COUNTP.
REQ-003 SHALL have parameter SPREG, default COUNT-1, index of the user stack pointer register.
REQ-004 SHALL have parameter NREAD, default 2, number of independent read ports (1..4).
REQ-005 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_i, input, 1, synchronous active-low reset.
REQ-007 SHALL have port supervisor, input, 1, which selects the banked supervisor SP (ssp) in place of register SPREG.
REQ-008 SHALL have port read_addr, input, NREAD*COUNTP, packed read addresses; port k occupies slice k.
REQ-009 SHALL have port read_data, output, NREAD*WIDTH, packed read data.
REQ-010 SHALL have port read_busy, output, NREAD, set when port k's register has an outstanding claim.
REQ-011 SHALL have ports write_addr (input, COUNTP), write_data (input, WIDTH) and write_en (input, 2), forming the general write port.
REQ-012 SHALL have ports sp_data_i (input, WIDTH), sp_en (input, 2) and sp_data_o (output, WIDTH), forming the stack pointer port.
REQ-013 SHALL have ports claim_valid (input, 1), claim_addr (input, COUNTP) and claim_ready (output, 1), forming the scoreboard claim handshake.
REQ-014 SHALL have port flush, input, 1, which clears all pending bits.
REQ-015 SHALL have port pending_cnt, output, COUNTP+1, the number of pending bits currently set.

Function
REQ-016 Enable encoding SHALL be: 00 no write; 01 bits [7:0] zero-extended; 10 bits [15:0] zero-extended; 11 full WIDTH.
REQ-017 General write SHALL update regfile[write_addr] at the clock edge when write_en != 00.
REQ-018 SP write SHALL go, when sp_en != 00, to ssp if supervisor=1, else to regfile[SPREG].
REQ-019 If both ports target regfile[SPREG] in the same cycle, the SP port SHALL win.
REQ-020 read_data[k] SHALL be combinational: ssp if supervisor=1 and addr=SPREG, else regfile[addr].
REQ-021 Bypass: read_data[k] SHALL return the same-cycle write value (extended per REQ-016) when the address matches.
REQ-022 Bypass priority SHALL follow REQ-019, with the SP port taking priority for address SPREG.
REQ-023 sp_data_o SHALL show the current SP (ssp or regfile[SPREG], per mode) with the same bypass rules.
REQ-024 Scoreboard: the block SHALL hold one pending bit per register, all 0 after reset.
REQ-025 A claim SHALL be accepted when claim_valid & claim_ready are both 1 at a clock edge.
REQ-026 An accepted claim SHALL set pending[claim_addr] at that edge.
REQ-027 claim_ready SHALL be 0 when claim_addr=SPREG.
REQ-028 claim_ready SHALL be 0 when flush=1.
REQ-029 claim_ready SHALL be 0 when pending[claim_addr]=1, unless that bit is being cleared this cycle by a general write to claim_addr.
REQ-030 A general write with write_en != 00 SHALL clear pending[write_addr] at the edge.
REQ-031 A same-cycle accepted claim to the same address SHALL take priority over the clear, leaving the bit set.
REQ-032 read_busy[k] SHALL equal pending[addr_k] AND NOT (general write to addr_k this cycle).
REQ-033 read_busy[k] SHALL be 0 for addr_k=SPREG.
REQ-034 flush=1 SHALL clear all pending bits at the edge, overriding claims; same-cycle register writes still occur.
REQ-035 pending_cnt SHALL be registered, equal to the popcount of pending bits after each edge, and range 0..COUNT-1.
REQ-036 Writes to a register that is not pending SHALL be legal and leave its pending bit at 0.

Reset
REQ-037 With rst_i=0 at an edge, all registers, ssp, pending bits and pending_cnt SHALL become 0; writes, claims and flush in that cycle are ignored.
REQ-038 During reset the combinational outputs SHALL reflect the zeroed state plus any bypass.
REQ-039 Reset mid-operation SHALL discard outstanding claims without leaving any residual busy indication.

Verification
REQ-040 Bench SHALL check: write r3=0xDEADBEEF with en=11, then en=01 value 0x12345678 -> read r3 = 0x00000078; same-cycle read shows bypassed value.
REQ-041 Bench SHALL check: supervisor=1, sp_en=11 with 0x1000 -> ssp=0x1000, r15 unchanged (0); supervisor=0 reads r15=0, sp_data_o=0.
REQ-042 Bench SHALL check: claim r5 accepted -> read_busy=1 on r5, pending_cnt=1; second claim r5 -> claim_ready=0; write r5 -> busy clears in the same cycle, pending_cnt=0 next edge.
REQ-043 Bench SHALL check: same-cycle write r5 plus claim r5 with r5 pending -> claim_ready=1, r5 still pending after the edge, data updated.
REQ-044 Bench SHALL check: claim r1, r2, r4, then flush together with a claim of r6 -> pending_cnt=0, r6 not pending, claim_ready=0 during flush.
REQ-045 Bench SHALL check: claims on r1 and r2 outstanding, then rst_i=0 for one cycle -> all reads 0, read_busy all 0, pending_cnt=0.
